// File: rtl/drv8874_bridge_ctrl.sv
// DRV8874 H-bridge control core: input decode, dead-time sequencing,
// wake timing, OCP deglitch/latch/auto-retry and TSD hold-off.
module drv8874_bridge_ctrl #(
    parameter int unsigned DEAD_CYC    = 4,
    parameter int unsigned TWAKE_CYC   = 16,
    parameter int unsigned OCP_DEG_CYC = 3,
    parameter int unsigned RETRY_CYC   = 64,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in1,
    input  logic       in2,
    input  logic       pmode,
    input  logic       nsleep,
    input  logic       ocp,
    input  logic       tsd,
    output logic       hs1,
    output logic       ls1,
    output logic       hs2,
    output logic       ls2,
    output logic       nfault,
    output logic [2:0] st
);

    localparam int unsigned SYNC_W = 5;
    localparam int unsigned OCW    = CNT_W + 1;

    typedef enum logic [2:0] {
        SLEEP = 3'd0,
        WAKE  = 3'd1,
        RUN   = 3'd2,
        DEAD  = 3'd3,
        F_OCP = 3'd4,
        F_TSD = 3'd5
    } state_t;

    state_t             state;
    logic [SYNC_W-1:0]  sync1;
    logic [SYNC_W-1:0]  sync2;
    logic [3:0]         gates;
    logic [3:0]         tgt;
    logic [3:0]         tgt_q;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_dec;
    logic               cnt_last;
    logic [CNT_W-1:0]   ocp_cnt;
    logic [OCW-1:0]     ocp_nxt;
    logic               ocp_trip;
    logic               s_in1, s_in2, s_nsleep, s_ocp, s_tsd;

    assign {s_in1, s_in2, s_nsleep, s_ocp, s_tsd} = sync2;
    assign {hs1, ls1, hs2, ls2} = gates;
    assign st = state;

    // Two-flop synchronisers for all asynchronous inputs (pmode is static)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {in1, in2, nsleep, ocp, tsd};
            sync2 <= sync1;
        end
    end

    // Target gate vector {hs1,ls1,hs2,ls2} from the synchronised inputs
    always_comb begin
        tgt = 4'b0000;
        if (pmode) begin
            case ({s_in1, s_in2})
                2'b01:   tgt = 4'b0110;
                2'b10:   tgt = 4'b1001;
                2'b11:   tgt = 4'b0101;
                default: tgt = 4'b0000;
            endcase
        end else if (!s_in1) begin
            tgt = 4'b0101;
        end else if (s_in2) begin
            tgt = 4'b1001;
        end else begin
            tgt = 4'b0110;
        end
    end

    // Saturating down-count; "last" fires on the cycle the count would reach 0,
    // so a load of N gives exactly N cycles in the timed state
    always_comb begin
        cnt_dec  = (cnt == '0) ? '0 : cnt - CNT_W'(1);
        cnt_last = (cnt_dec == '0);
        ocp_nxt  = {1'b0, ocp_cnt} + OCW'(1);
        ocp_trip = s_ocp && (ocp_nxt >= OCW'(OCP_DEG_CYC));
    end

    // Bridge state machine: sleep > tsd > ocp latch > normal sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SLEEP;
            gates   <= 4'b0000;
            nfault  <= 1'b1;
            cnt     <= '0;
            ocp_cnt <= '0;
            tgt_q   <= 4'b0000;
        end else if (!s_nsleep) begin
            state   <= SLEEP;
            gates   <= 4'b0000;
            nfault  <= 1'b1;
            cnt     <= '0;
            ocp_cnt <= '0;
        end else if (s_tsd && (state inside {WAKE, RUN, DEAD, F_OCP})) begin
            state   <= F_TSD;
            gates   <= 4'b0000;
            nfault  <= 1'b0;
            cnt     <= '0;
            ocp_cnt <= '0;
        end else if (ocp_trip && (state inside {RUN, DEAD})) begin
            state   <= F_OCP;
            gates   <= 4'b0000;
            nfault  <= 1'b0;
            cnt     <= CNT_W'(RETRY_CYC);
            ocp_cnt <= '0;
        end else begin
            if ((state inside {RUN, DEAD}) && s_ocp) begin
                ocp_cnt <= ocp_nxt[CNT_W-1:0];
            end else begin
                ocp_cnt <= '0;
            end
            case (state)
                SLEEP: begin
                    state <= WAKE;
                    cnt   <= CNT_W'(TWAKE_CYC);
                end
                WAKE: begin
                    if (cnt_last) begin
                        state <= RUN;
                        gates <= 4'b0000;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_dec;
                    end
                end
                RUN: begin
                    if ((tgt & ~gates) == 4'b0000) begin
                        gates <= tgt;
                    end else begin
                        gates <= gates & tgt;
                        tgt_q <= tgt;
                        cnt   <= CNT_W'(DEAD_CYC);
                        state <= DEAD;
                    end
                end
                DEAD: begin
                    if (tgt != tgt_q) begin
                        gates <= gates & tgt;
                        tgt_q <= tgt;
                        cnt   <= CNT_W'(DEAD_CYC);
                    end else if (cnt_last) begin
                        gates <= tgt;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt_dec;
                    end
                end
                F_OCP: begin
                    if (cnt_last) begin
                        nfault <= 1'b1;
                        gates  <= 4'b0000;
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        cnt <= cnt_dec;
                    end
                end
                F_TSD: begin
                    if (!s_tsd) begin
                        nfault <= 1'b1;
                        gates  <= 4'b0000;
                        state  <= RUN;
                    end
                end
                default: begin
                    state  <= SLEEP;
                    gates  <= 4'b0000;
                    nfault <= 1'b1;
                    cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drv8874_bridge_ctrl.sv
// Directed testbench for drv8874_bridge_ctrl.
module tb_drv8874_bridge_ctrl;

    localparam int DEAD = 4;

    logic       clk = 1'b0;
    logic       rst_n, in1, in2, pmode, nsleep, ocp, tsd;
    logic       hs1, ls1, hs2, ls2, nfault;
    logic [2:0] st;
    logic [3:0] gates;
    logic [3:0] prev_g;
    int         zc [4];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    assign gates = {hs1, ls1, hs2, ls2};

    drv8874_bridge_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .pmode(pmode),
        .nsleep(nsleep), .ocp(ocp), .tsd(tsd),
        .hs1(hs1), .ls1(ls1), .hs2(hs2), .ls2(ls2), .nfault(nfault), .st(st)
    );

    // Advance to the next falling edge and check leg overlap / dead time
    task automatic step();
        @(negedge clk);
        if (rst_n) begin
            checks++;
            if ((gates[3] & gates[2]) || (gates[1] & gates[0])) begin
                errors++;
                $display("FAIL shoot_through: gates=%b required no leg overlap", gates);
            end
            for (int i = 0; i < 4; i++) begin
                if (gates[i] && !prev_g[i]) begin
                    checks++;
                    if (zc[i ^ 1] < DEAD) begin
                        errors++;
                        $display("FAIL dead_time: gate %0d rose after %0d partner-off cycles, required >= %0d",
                                 i, zc[i ^ 1], DEAD);
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) zc[i] = gates[i] ? 0 : ((zc[i] < 1000) ? zc[i] + 1 : zc[i]);
        prev_g = gates;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pmode = 1'b1; in1 = 1'b1; in2 = 1'b0;
        nsleep = 1'b1; ocp = 1'b0; tsd = 1'b0;
        prev_g = 4'b0000;
        for (int i = 0; i < 4; i++) zc[i] = 0;
        repeat (3) step();
        checks++;
        if (gates !== 4'b0000 || nfault !== 1'b1 || st !== 3'd0) begin
            errors++;
            $display("FAIL reset: gates=%b nfault=%b st=%0d required 0000 1 0", gates, nfault, st);
        end
    endtask

    task automatic test_wake_fwd();
        int n;
        rst_n = 1'b1;
        repeat (2) step();
        checks++;
        if (st !== 3'd0) begin
            errors++;
            $display("FAIL wake_sync_latency: st=%0d required 0", st);
        end
        step();
        checks++;
        if (st !== 3'd1) begin
            errors++;
            $display("FAIL wake_entry: st=%0d required 1", st);
        end
        n = 0;
        while (st === 3'd1 && n < 100) begin
            if (gates !== 4'b0000) begin
                errors++;
                $display("FAIL wake_gates: gates=%b required 0000", gates);
            end
            n++;
            step();
        end
        checks++;
        if (n != 16 || st !== 3'd2) begin
            errors++;
            $display("FAIL wake_length: %0d cycles st=%0d required 16 cycles then st 2", n, st);
        end
        n = 0;
        while (gates === 4'b0000 && n < 50) begin
            n++;
            step();
        end
        checks++;
        if (n != DEAD + 1 || gates !== 4'b1001) begin
            errors++;
            $display("FAIL fwd_latency: %0d cycles gates=%b required %0d cycles then 1001", n, gates, DEAD + 1);
        end
    endtask

    task automatic test_pwm_reversal();
        logic [3:0] exp_seq [8];
        exp_seq = '{4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0110};
        in1 = 1'b0; in2 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (gates !== exp_seq[k]) begin
                errors++;
                $display("FAIL fwd_to_rev[%0d]: gates=%b required %b", k, gates, exp_seq[k]);
            end
        end
    endtask

    task automatic test_pwm_brake_coast();
        logic [3:0] exp_b [7];
        logic [3:0] exp_c [3];
        exp_b = '{4'b1001, 4'b1001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0101};
        exp_c = '{4'b0101, 4'b0101, 4'b0000};
        in1 = 1'b1; in2 = 1'b0;
        repeat (10) step();
        checks++;
        if (gates !== 4'b1001) begin
            errors++;
            $display("FAIL back_to_fwd: gates=%b required 1001", gates);
        end
        in1 = 1'b1; in2 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            checks++;
            if (gates !== exp_b[k]) begin
                errors++;
                $display("FAIL fwd_to_brake[%0d]: gates=%b required %b", k, gates, exp_b[k]);
            end
        end
        in1 = 1'b0; in2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (gates !== exp_c[k]) begin
                errors++;
                $display("FAIL brake_to_coast[%0d]: gates=%b required %b", k, gates, exp_c[k]);
            end
        end
    endtask

    task automatic test_phen();
        logic [3:0] exp_f [7];
        logic [3:0] e;
        exp_f = '{4'b0101, 4'b0101, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1001};
        pmode = 1'b0;
        repeat (8) step();
        checks++;
        if (gates !== 4'b0101) begin
            errors++;
            $display("FAIL phen_en0_brake: gates=%b required 0101", gates);
        end
        in1 = 1'b1; in2 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            checks++;
            if (gates !== exp_f[k]) begin
                errors++;
                $display("FAIL phen_fwd[%0d]: gates=%b required %b", k, gates, exp_f[k]);
            end
        end
        in2 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            e = (k <= 2) ? 4'b1001 : ((k <= 14) ? 4'b0000 : 4'b0110);
            checks++;
            if (gates !== e || ((k >= 3 && k <= 14) && st !== 3'd3)) begin
                errors++;
                $display("FAIL ph_toggle[%0d]: gates=%b st=%0d required %b", k, gates, st, e);
            end
            if (k == 2 || k == 4 || k == 6 || k == 8) in2 = ((k / 2) % 2 == 1);
        end
    endtask

    task automatic test_ocp();
        int n;
        ocp = 1'b1;
        repeat (2) step();
        ocp = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (nfault !== 1'b1 || gates !== 4'b0110) begin
                errors++;
                $display("FAIL ocp_glitch[%0d]: nfault=%b gates=%b required 1 0110", k, nfault, gates);
            end
        end
        ocp = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 3) ocp = 1'b0;
            if (k < 5) begin
                checks++;
                if (nfault !== 1'b1 || gates !== 4'b0110) begin
                    errors++;
                    $display("FAIL ocp_deglitch[%0d]: nfault=%b gates=%b required 1 0110", k, nfault, gates);
                end
            end
        end
        checks++;
        if (nfault !== 1'b0 || gates !== 4'b0000 || st !== 3'd4) begin
            errors++;
            $display("FAIL ocp_latch: nfault=%b gates=%b st=%0d required 0 0000 4", nfault, gates, st);
        end
        n = 0;
        while (st === 3'd4 && n < 200) begin
            if (nfault !== 1'b0 || gates !== 4'b0000) begin
                errors++;
                $display("FAIL ocp_hold: nfault=%b gates=%b required 0 0000", nfault, gates);
            end
            n++;
            step();
        end
        checks++;
        if (n != 64 || st !== 3'd2 || nfault !== 1'b1 || gates !== 4'b0000) begin
            errors++;
            $display("FAIL ocp_retry: %0d cycles st=%0d nfault=%b gates=%b required 64 2 1 0000",
                     n, st, nfault, gates);
        end
        n = 0;
        while (gates === 4'b0000 && n < 50) begin
            n++;
            step();
        end
        checks++;
        if (n != DEAD + 1 || gates !== 4'b0110) begin
            errors++;
            $display("FAIL ocp_resume: %0d cycles gates=%b required %0d then 0110", n, gates, DEAD + 1);
        end
    endtask

    task automatic test_tsd_sleep();
        in2 = 1'b1;
        repeat (10) step();
        checks++;
        if (gates !== 4'b1001) begin
            errors++;
            $display("FAIL tsd_pre_fwd: gates=%b required 1001", gates);
        end
        tsd = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            checks++;
            if (k <= 2) begin
                if (gates !== 4'b1001 || nfault !== 1'b1) begin
                    errors++;
                    $display("FAIL tsd_sync[%0d]: gates=%b nfault=%b required 1001 1", k, gates, nfault);
                end
            end else if (k <= 8) begin
                if (st !== 3'd5 || nfault !== 1'b0 || gates !== 4'b0000) begin
                    errors++;
                    $display("FAIL tsd_hold[%0d]: st=%0d nfault=%b gates=%b required 5 0 0000", k, st, nfault, gates);
                end
            end else begin
                if (st !== 3'd2 || nfault !== 1'b1 || gates !== 4'b0000) begin
                    errors++;
                    $display("FAIL tsd_release: st=%0d nfault=%b gates=%b required 2 1 0000", st, nfault, gates);
                end
            end
            if (k == 6) tsd = 1'b0;
        end
        tsd = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k >= 3 && k <= 6) begin
                checks++;
                if (st !== 3'd5 || nfault !== 1'b0) begin
                    errors++;
                    $display("FAIL tsd_again[%0d]: st=%0d nfault=%b required 5 0", k, st, nfault);
                end
            end
            if (k == 4) nsleep = 1'b0;
        end
        checks++;
        if (st !== 3'd0 || nfault !== 1'b1 || gates !== 4'b0000) begin
            errors++;
            $display("FAIL sleep_from_tsd: st=%0d nfault=%b gates=%b required 0 1 0000", st, nfault, gates);
        end
    endtask

    task automatic test_reset_mid_dead();
        int n;
        tsd = 1'b0; nsleep = 1'b1;
        n = 0;
        while (gates !== 4'b1001 && n < 60) begin
            n++;
            step();
        end
        checks++;
        if (gates !== 4'b1001) begin
            errors++;
            $display("FAIL rewake_fwd: gates=%b after %0d cycles required 1001", gates, n);
        end
        in1 = 1'b0;
        repeat (3) step();
        checks++;
        if (st !== 3'd3 || gates !== 4'b0001) begin
            errors++;
            $display("FAIL pre_reset_dead: st=%0d gates=%b required 3 0001", st, gates);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (gates !== 4'b0000 || st !== 3'd0 || nfault !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: gates=%b st=%0d nfault=%b required 0000 0 1", gates, st, nfault);
        end
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_wake_fwd();
        test_pwm_reversal();
        test_pwm_brake_coast();
        test_phen();
        test_ocp();
        test_tsd_sleep();
        test_reset_mid_dead();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
